wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the pipeline write-back stage and a
//  long-latency unit (LLU: mul/div). Pipeline always wins. LLU results wait in a DEPTH-entry
//  FIFO and drain in idle write-back slots. A starvation guard stalls the pipe one cycle.
//  Sits between write-back stage / LLU and the register-file write port.
// PARAMETERS
//  DATA_W    32  write data width
//  ADDR_W    5   register index width; index 0 is never written
//  DEPTH     4   LLU pending FIFO entries (power of 2, >=2)
//  MAX_WAIT  8   consecutive cycles head may wait before a forced drain (>=1)
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               asynchronous, active-low; 0 = reset asserted
//  pipe_we      in   1               write-back stage write request
//  pipe_rd      in   ADDR_W          write-back destination register
//  pipe_data    in   DATA_W          write-back data
//  llu_valid    in   1               LLU result valid
//  llu_rd       in   ADDR_W          LLU destination register
//  llu_data     in   DATA_W          LLU result data
//  llu_ready    out  1               FIFO can accept; handshake = llu_valid & llu_ready
//  rf_we        out  1               register-file write enable (registered)
//  rf_rd        out  ADDR_W          register-file write address (registered)
//  rf_wdata     out  DATA_W          register-file write data (registered)
//  pipe_stall   out  1               hold pipeline this cycle (registered)
//  pend_cnt     out  $clog2(DEPTH)+1 valid+squashed entries in FIFO
// BEHAVIOUR
//  - Reset (reset=0, async): rf_we/rf_rd/rf_wdata/pipe_stall=0, FIFO empty, pend_cnt=0,
//    wait counter=0, state IDLE. llu_ready=1 once reset deasserts.
//  - llu_ready = (pend_cnt < DEPTH), from registered count. Same-cycle push+pop keeps count.
//  - Accepted LLU result with llu_rd==0 is consumed and discarded (not queued).
//  - While pipe_stall=1, pipe_we is ignored (upstream holds the instruction).
//  - Slot select per cycle, priority order:
//    1. pipe_we & pipe_rd!=0 -> write pipe_rd/pipe_data. pipe_rd==0 is an idle slot.
//    2. FIFO non-empty -> pop head. Write it only if head is not squashed, else rf_we=0.
//    3. Else nothing: rf_we=0; rf_rd/rf_wdata hold their previous values.
//  - Latency: pipe write -> rf_* next edge (1 cycle). Queued LLU result: >=2 cycles.
//  - WAW squash: a pipe write to R marks every queued entry with rd==R squashed.
//    An LLU result accepted in the same cycle with rd==R is newer and is NOT squashed.
//  - FSM: IDLE (FIFO empty), PEND (non-empty), FORCE.
//    IDLE->PEND on push with no same-cycle pop.
//    PEND->IDLE when the last entry pops with no push.
//    In PEND, wait_cnt increments each cycle the head is not popped and clears on every pop.
//    PEND->FORCE when wait_cnt reaches MAX_WAIT-1 and no pop occurs.
//    FORCE: pipe_stall=1 for exactly one cycle; head pops that cycle; wait_cnt=0.
//    Then -> PEND if entries remain, else IDLE.
//  - Full FIFO: llu_ready=0. The LLU holds valid/data stable until accepted.
//  - Pointers wrap modulo DEPTH. pend_cnt never exceeds DEPTH.
//  - reset mid-operation: queued entries are lost. The LLU must be reset by the same signal.
// CONFIGURATION
//  WB_LLU_BYPASS_EN defined:
//    FIFO empty, slot idle and LLU handshake in the same cycle -> LLU result written directly.
//    Next edge: 1-cycle latency, no FIFO entry.
//  Not defined: every LLU result passes through the FIFO (minimum 2 cycles).
// TESTING
//  1 Reset: drive reset=0 mid-traffic -> all outputs 0 at once; pend_cnt=0; llu_ready=1 after.
//  2 Pipe only: pipe_we=1, rd=5, data=0xA5A5A5A5 -> next edge rf_we=1, rf_rd=5,
//    rf_wdata=0xA5A5A5A5. Same with rd=0 -> rf_we=0.
//  3 Queue + drain: LLU rd=7, data=0x11 while pipe_we=1 for 3 cycles -> pend_cnt=1.
//    On the first cycle with pipe_we=0: rf_rd=7, rf_wdata=0x11; pend_cnt=0.
//  4 Full: pipe_we=1 continuously, 5 LLU pushes, DEPTH=4 -> llu_ready=0 after the 4th.
//    Starvation: pipe_stall pulses 1 cycle after MAX_WAIT=8 waits; one entry drains.
//  5 WAW: queue rd=9/0x22, then pipe writes rd=9/0x33 -> rf gets 0x33; squashed head pops with
//    rf_we=0. Simultaneous LLU rd=9 in the same cycle is kept and written later.
//  6 Bypass: FIFO empty, pipe idle, LLU rd=3/0x44 -> with WB_LLU_BYPASS_EN rf write next edge;
//    without it, rf write two edges later.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Write-back arbiter bus: pipe and LLU requests in,
// register-file write port and backpressure out.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 3
);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              llu_valid;
  logic [ADDR_W-1:0] llu_rd;
  logic [DATA_W-1:0] llu_data;
  logic              llu_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic              pipe_stall;
  logic [CNT_W-1:0]  pend_cnt;

  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output llu_valid, llu_rd, llu_data,
    input  llu_ready, rf_we, rf_rd, rf_wdata,
    input  pipe_stall, pend_cnt
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  llu_valid, llu_rd, llu_data,
    output llu_ready, rf_we, rf_rd, rf_wdata,
    output pipe_stall, pend_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipe first, LLU via FIFO.
// Define WB_LLU_BYPASS_EN to write LLU results directly when idle.
module wb_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LIM =
    WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] q_rd   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_sq;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;

  logic              empty, hs, pipe_ok;
  logic              push, pop, bypass;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  assign bus.llu_ready = reset & (cnt < FULL);
  assign bus.pend_cnt  = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    unique case (state)
      IDLE: begin
        if (push && !pop) state_nxt = PEND;
      end
      PEND: begin
        if (pop) begin
          wait_nxt = '0;
          if (cnt_nxt == '0) state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LIM) begin
          state_nxt = FORCE;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      FORCE: begin
        wait_nxt  = '0;
        state_nxt = (cnt_nxt == '0) ? IDLE : PEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // While stalled the pipe request is ignored, so the head wins the slot.
  always_comb begin
    empty   = (cnt == '0);
    hs      = bus.llu_valid & bus.llu_ready;
    pipe_ok = bus.pipe_we & ~bus.pipe_stall
            & (bus.pipe_rd != '0);
    pop     = ~pipe_ok & ~empty;
    bypass  = 1'b0;
`ifdef WB_LLU_BYPASS_EN
    bypass  = empty & ~pipe_ok & hs
            & (bus.llu_rd != '0);
`endif
    push    = hs & (bus.llu_rd != '0) & ~bypass;
    cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);
    wb_we   = 1'b0;
    wb_rd   = bus.rf_rd;
    wb_data = bus.rf_wdata;
    unique case (1'b1)
      pipe_ok: begin
        wb_we   = 1'b1;
        wb_rd   = bus.pipe_rd;
        wb_data = bus.pipe_data;
      end
      pop: begin
        if (!q_sq[rd_ptr]) begin
          wb_we   = 1'b1;
          wb_rd   = q_rd[rd_ptr];
          wb_data = q_data[rd_ptr];
        end
      end
      bypass: begin
        wb_we   = 1'b1;
        wb_rd   = bus.llu_rd;
        wb_data = bus.llu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      q_sq           <= '0;
      bus.rf_we      <= 1'b0;
      bus.rf_rd      <= '0;
      bus.rf_wdata   <= '0;
      bus.pipe_stall <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      bus.rf_we      <= wb_we;
      bus.rf_rd      <= wb_rd;
      bus.rf_wdata   <= wb_data;
      bus.pipe_stall <= (state_nxt == FORCE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A newer pipe write kills older queued results to the same reg.
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_ok && q_rd[i] == bus.pipe_rd)
          q_sq[i] <= 1'b1;
      end
      if (push) q_sq[wr_ptr] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= bus.llu_rd;
      q_data[wr_ptr] <= bus.llu_data;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model,
// directed scenarios and randomized traffic.
module tb_wb_port_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic clk;
  logic reset;

  wb_port_arbiter_if #(
    .DATA_W(32), .ADDR_W(5), .CNT_W(3)
  ) bus ();

  wb_port_arbiter #(
    .DATA_W(32), .ADDR_W(5),
    .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          sq;
  } ent_t;

  ent_t        q[$];
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wdata;
  logic        exp_stall;
  int          exp_pend;
  logic        nxt_we;
  logic [4:0]  nxt_rd;
  logic [31:0] nxt_wdata;
  logic        nxt_stall;
  int          m_wait;
  bit          m_acc;
  bit          chk_en;
  int          n_chk;
  int          n_err;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: what one clock edge does, from the current inputs.
  task automatic model_step();
    int   sz;
    bit   pok, hs, pop, byp;
    ent_t h, e;
    sz  = q.size();
    pok = bus.pipe_we && !exp_stall
          && bus.pipe_rd != 0;
    hs  = bus.llu_valid && sz < DEPTH;
    pop = !pok && sz > 0;
    byp = 1'b0;
`ifdef WB_LLU_BYPASS_EN
    byp = sz == 0 && !pok && hs
          && bus.llu_rd != 0;
`endif
    nxt_we    = 1'b0;
    nxt_rd    = exp_rd;
    nxt_wdata = exp_wdata;
    if (pok) begin
      nxt_we    = 1'b1;
      nxt_rd    = bus.pipe_rd;
      nxt_wdata = bus.pipe_data;
      foreach (q[i])
        if (q[i].rd == bus.pipe_rd) q[i].sq = 1'b1;
    end else if (pop) begin
      h = q.pop_front();
      if (!h.sq) begin
        nxt_we    = 1'b1;
        nxt_rd    = h.rd;
        nxt_wdata = h.data;
      end
    end else if (byp) begin
      nxt_we    = 1'b1;
      nxt_rd    = bus.llu_rd;
      nxt_wdata = bus.llu_data;
    end
    if (hs && bus.llu_rd != 0 && !byp) begin
      e.rd   = bus.llu_rd;
      e.data = bus.llu_data;
      e.sq   = 1'b0;
      q.push_back(e);
    end
    nxt_stall = 1'b0;
    if (exp_stall || pop) begin
      m_wait = 0;
    end else if (sz > 0) begin
      if (m_wait == MAX_WAIT - 1) begin
        nxt_stall = 1'b1;
        m_wait    = 0;
      end else begin
        m_wait++;
      end
    end
    m_acc = hs;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    exp_we    = nxt_we;
    exp_rd    = nxt_rd;
    exp_wdata = nxt_wdata;
    exp_stall = nxt_stall;
    exp_pend  = q.size();
    #2;
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("rf_we", 32'(bus.rf_we), 32'(exp_we));
      chk("rf_rd", 32'(bus.rf_rd), 32'(exp_rd));
      chk("rf_wdata", bus.rf_wdata, exp_wdata);
      chk("pipe_stall", 32'(bus.pipe_stall),
          32'(exp_stall));
      chk("pend_cnt", 32'(bus.pend_cnt),
          32'(exp_pend));
      chk("llu_ready", 32'(bus.llu_ready),
          32'(reset && exp_pend < DEPTH));
    end
  end

  task automatic set_pipe(logic we, logic [4:0] rd,
                          logic [31:0] d);
    bus.pipe_we   = we;
    bus.pipe_rd   = rd;
    bus.pipe_data = d;
  endtask

  task automatic set_llu(logic v, logic [4:0] rd,
                         logic [31:0] d);
    bus.llu_valid = v;
    bus.llu_rd    = rd;
    bus.llu_data  = d;
  endtask

  task automatic do_reset();
    set_pipe(1'b0, 5'd0, 32'd0);
    set_llu(1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    q.delete();
    exp_we    = 1'b0;
    exp_rd    = '0;
    exp_wdata = '0;
    exp_stall = 1'b0;
    exp_pend  = 0;
    m_wait    = 0;
    m_acc     = 1'b0;
    #1;
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rd", 32'(bus.rf_rd), 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_stall", 32'(bus.pipe_stall), 32'd0);
    chk("rst_pend", 32'(bus.pend_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.llu_ready), 32'd1);
  endtask

  task automatic rand_phase(int n, int p_pipe,
                            int p_llu);
    for (int c = 0; c < n; c++) begin
      if (!(bus.llu_valid && !m_acc)) begin
        bus.llu_valid = $urandom_range(99) < p_llu;
        bus.llu_rd    = 5'($urandom_range(7));
        bus.llu_data  = $urandom;
      end
      bus.pipe_we   = $urandom_range(99) < p_pipe;
      bus.pipe_rd   = 5'($urandom_range(7));
      bus.pipe_data = $urandom;
      tick();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    do_reset();
    chk_en = 1'b1;

    // pipe-only writes
    set_pipe(1'b1, 5'd5, 32'hA5A5A5A5);
    tick();
    chk("pipe_we", 32'(bus.rf_we), 32'd1);
    chk("pipe_rd", 32'(bus.rf_rd), 32'd5);
    chk("pipe_data", bus.rf_wdata, 32'hA5A5A5A5);
    set_pipe(1'b1, 5'd0, 32'h12345678);
    tick();
    chk("pipe_rd0_we", 32'(bus.rf_we), 32'd0);
    chk("pipe_rd0_hold", 32'(bus.rf_rd), 32'd5);

    // queue while pipe busy, drain in first idle slot
    set_pipe(1'b1, 5'd1, 32'h1);
    set_llu(1'b1, 5'd7, 32'h11);
    tick();
    set_llu(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    chk("q_pend", 32'(bus.pend_cnt), 32'd1);
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    chk("drain_we", 32'(bus.rf_we), 32'd1);
    chk("drain_rd", 32'(bus.rf_rd), 32'd7);
    chk("drain_data", bus.rf_wdata, 32'h11);
    chk("drain_pend", 32'(bus.pend_cnt), 32'd0);

    // full FIFO and starvation guard
    set_pipe(1'b1, 5'd2, 32'h2222);
    for (int i = 0; i < 4; i++) begin
      set_llu(1'b1, 5'(10 + i), 32'(256 + i));
      tick();
    end
    chk("full_ready", 32'(bus.llu_ready), 32'd0);
    chk("full_pend", 32'(bus.pend_cnt), 32'd4);
    set_llu(1'b1, 5'd14, 32'd260);
    repeat (4) tick();
    chk("no_stall_yet", 32'(bus.pipe_stall), 32'd0);
    tick();
    chk("stall_pulse", 32'(bus.pipe_stall), 32'd1);
    tick();
    chk("force_we", 32'(bus.rf_we), 32'd1);
    chk("force_rd", 32'(bus.rf_rd), 32'd10);
    chk("stall_drop", 32'(bus.pipe_stall), 32'd0);
    chk("force_pend", 32'(bus.pend_cnt), 32'd3);
    tick();
    chk("fifth_push", 32'(bus.pend_cnt), 32'd4);
    set_llu(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    repeat (4) tick();
    chk("last_rd", 32'(bus.rf_rd), 32'd14);
    chk("last_data", bus.rf_wdata, 32'd260);
    chk("empty_pend", 32'(bus.pend_cnt), 32'd0);

    // WAW squash, same-cycle newer LLU result survives
    set_pipe(1'b1, 5'd1, 32'h1);
    set_llu(1'b1, 5'd9, 32'h22);
    tick();
    set_pipe(1'b1, 5'd9, 32'h33);
    set_llu(1'b1, 5'd9, 32'h55);
    tick();
    chk("waw_rd", 32'(bus.rf_rd), 32'd9);
    chk("waw_data", bus.rf_wdata, 32'h33);
    chk("waw_pend", 32'(bus.pend_cnt), 32'd2);
    set_pipe(1'b0, 5'd0, 32'd0);
    set_llu(1'b0, 5'd0, 32'd0);
    tick();
    chk("squash_we", 32'(bus.rf_we), 32'd0);
    chk("squash_hold", bus.rf_wdata, 32'h33);
    tick();
    chk("kept_we", 32'(bus.rf_we), 32'd1);
    chk("kept_data", bus.rf_wdata, 32'h55);

    // LLU result to x0 is dropped
    set_llu(1'b1, 5'd0, 32'h77);
    tick();
    chk("x0_pend", 32'(bus.pend_cnt), 32'd0);
    chk("x0_we", 32'(bus.rf_we), 32'd0);

    // idle slot: direct write or two-edge path
    set_llu(1'b1, 5'd3, 32'h44);
    tick();
    set_llu(1'b0, 5'd0, 32'd0);
`ifdef WB_LLU_BYPASS_EN
    chk("byp_we", 32'(bus.rf_we), 32'd1);
    chk("byp_data", bus.rf_wdata, 32'h44);
    chk("byp_pend", 32'(bus.pend_cnt), 32'd0);
`else
    chk("nobyp_we", 32'(bus.rf_we), 32'd0);
    chk("nobyp_pend", 32'(bus.pend_cnt), 32'd1);
    tick();
    chk("nobyp_we2", 32'(bus.rf_we), 32'd1);
    chk("nobyp_data", bus.rf_wdata, 32'h44);
`endif

    rand_phase(1000, 85, 60);
    do_reset();
    rand_phase(1000, 50, 40);
    do_reset();
    rand_phase(1500, 95, 80);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
